// File: rtl/sphere_seq_pkg.sv
// Shared definitions for the sphere point sequencer: default widths,
// FSM state codes and a few Q16.16 reference constants.
package sphere_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH_DEF  = 2;

  // FSM state codes, kept as plain 2-bit constants for legacy tools
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Q16.16 two's complement reference values
  localparam logic [31:0] Q16_ZERO     = 32'h0000_0000;
  localparam logic [31:0] Q16_ONE      = 32'h0001_0000;
  localparam logic [31:0] Q16_NEG_HALF = 32'hFFFF_8000;

endpackage

// File: rtl/sphere_result_fifo.sv
// Small synchronous FIFO holding (k, x, y, z) result beats between the
// point-generator core and the downstream consumer. Push while full is only
// accepted when a pop happens in the same cycle; pop while empty is ignored.
module sphere_result_fifo #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_FW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_FW-1:0] count_o
);

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_FW-1:0] FULL_CNT  = CNT_FW'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0] count_q;
  logic              do_push, do_pop;

  // Qualify requests: never pop empty, only push full when a pop frees a slot
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != FULL_CNT) || do_pop);
  end

  // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sphere_point_sequencer.sv
// Sequencer that walks k over a programmed range, issues one point-generator
// core job per index (one job in flight at most), buffers each result and
// streams (k, x, y, z) beats out over a valid/ready port.
module sphere_point_sequencer
  import sphere_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] cfg_k_start,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [1:0]        cfg_base_sel0,
  input  logic [1:0]        cfg_base_sel1,
  output logic              busy,
  output logic              run_done,
  output logic              core_start,
  output logic [DATA_W-1:0] core_k,
  output logic [1:0]        core_base_sel0,
  output logic [1:0]        core_base_sel1,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_x,
  input  logic [DATA_W-1:0] core_y,
  input  logic [DATA_W-1:0] core_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_k,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_z
);

  localparam int BEAT_W = 4 * DATA_W;
  localparam int CNT_FW = $clog2(DEPTH + 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [1:0]        bs0_q, bs0_d, bs1_q, bs1_d;

  logic              fifo_push, fifo_full, fifo_empty;
  logic [CNT_FW-1:0] fifo_count;
  logic [BEAT_W-1:0] fifo_head;
  logic              issue_ok;

  sphere_result_fifo #(
    .WIDTH(BEAT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .data_i ({k_q, core_x, core_y, core_z}),
    .pop_i  (out_ready),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // A job may start only when the core is idle and a buffer slot is free, so
  // the capture in WAIT can never overflow even if the consumer stalls
  always_comb begin
    issue_ok  = (state_q == ST_ISSUE) && core_ready && !fifo_full;
    fifo_push = (state_q == ST_WAIT) && core_done;
  end

  // Next-state logic: config latch, index walk and run sequencing
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    remaining_d = remaining_q;
    bs0_d       = bs0_q;
    bs1_d       = bs1_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          k_d         = cfg_k_start;
          remaining_d = cfg_count;
          bs0_d       = cfg_base_sel0;
          bs1_d       = cfg_base_sel1;
          state_d     = (cfg_count == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          k_d         = k_q + DATA_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_d != '0) ? ST_ISSUE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers, cleared immediately on reset even mid-run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      remaining_q <= '0;
      bs0_q       <= '0;
      bs1_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      remaining_q <= remaining_d;
      bs0_q       <= bs0_d;
      bs1_q       <= bs1_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign run_done       = (state_q == ST_DRAIN) && (fifo_count == '0);
  assign core_start     = issue_ok;
  assign core_k         = k_q;
  assign core_base_sel0 = bs0_q;
  assign core_base_sel1 = bs1_q;
  assign out_valid      = !fifo_empty;
  assign out_k          = fifo_head[4*DATA_W-1 -: DATA_W];
  assign out_x          = fifo_head[3*DATA_W-1 -: DATA_W];
  assign out_y          = fifo_head[2*DATA_W-1 -: DATA_W];
  assign out_z          = fifo_head[DATA_W-1 -: DATA_W];

endmodule

// File: tb/tb_sphere_point_sequencer.sv
// Scoreboard bench for sphere_point_sequencer with a behavioural
// fixed-latency point-generator core model.
module tb_sphere_point_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 2;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic [DATA_W-1:0] cfg_k_start = '0;
  logic [CNT_W-1:0]  cfg_count = '0;
  logic [1:0]        cfg_base_sel0 = '0, cfg_base_sel1 = '0;
  logic              busy, run_done, core_start;
  logic [DATA_W-1:0] core_k;
  logic [1:0]        core_base_sel0, core_base_sel1;
  logic              core_ready, core_done;
  logic [DATA_W-1:0] core_x, core_y, core_z;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_k, out_x, out_y, out_z;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;

  logic [127:0] exp_beats[$];
  logic [31:0]  exp_issue[$];
  logic [1:0]   exp_bs0 = '0, exp_bs1 = '0;

  always #5 clk = ~clk;

  sphere_point_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_k_start(cfg_k_start), .cfg_count(cfg_count),
    .cfg_base_sel0(cfg_base_sel0), .cfg_base_sel1(cfg_base_sel1),
    .busy(busy), .run_done(run_done),
    .core_start(core_start), .core_k(core_k),
    .core_base_sel0(core_base_sel0), .core_base_sel1(core_base_sel1),
    .core_ready(core_ready), .core_done(core_done),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_k(out_k), .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  // Core result functions: arbitrary but distinct per k; k=1 -> z=0, k=2 -> z=-0.5
  function automatic logic [31:0] fx(input logic [31:0] k);
    return k * 32'd3 + 32'd7;
  endfunction
  function automatic logic [31:0] fy(input logic [31:0] k);
    return ~k ^ 32'h0001_0000;
  endfunction
  function automatic logic [31:0] fz(input logic [31:0] k);
    if (k == 32'd1) return 32'h0000_0000;
    if (k == 32'd2) return 32'hFFFF_8000;
    return {k[15:0], k[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Behavioural core: fixed latency, not ready while busy, done held until next start
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_k <= '0; core_done <= 1'b0;
      core_x <= '0; core_y <= '0; core_z <= '0;
    end else if (core_start) begin
      m_busy <= 1'b1; m_cnt <= LAT; m_k <= core_k; core_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0; core_done <= 1'b1;
        core_x <= fx(m_k); core_y <= fy(m_k); core_z <= fz(m_k);
      end
      m_cnt <= m_cnt - 1;
    end
  end
  assign core_ready = !m_busy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and core job start
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic [127:0] cur_data;
  always @(negedge clk) begin
    cur_data = {out_k, out_x, out_y, out_z};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (core_start) begin
        n_start++;
        check("core_ready at start", core_ready, 1'b1);
        if (exp_issue.size() == 0) fail("unexpected core_start");
        else check("core_k at start", core_k, exp_issue.pop_front());
      end
      if (m_busy) begin
        check("core_k held", core_k, m_k);
        check("base_sel held", {core_base_sel0, core_base_sel1}, {exp_bs0, exp_bs1});
      end
      if (run_done) n_done++;
      if (prev_stall) check("stalled beat stable", {out_valid, cur_data}, {1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) fail("unexpected beat");
        else check("beat k/x/y/z", cur_data, exp_beats.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = cur_data;
    end
  end

  task automatic drive_ready(input int mode);
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic start_run(input logic [31:0] k0, input logic [15:0] cnt,
                           input logic [1:0] b0, input logic [1:0] b1);
    for (int i = 0; i < int'(cnt); i++) begin
      logic [31:0] k;
      k = k0 + 32'(i);
      exp_issue.push_back(k);
      exp_beats.push_back({k, fx(k), fy(k), fz(k)});
    end
    exp_bs0 = b0; exp_bs1 = b1;
    cfg_k_start = k0; cfg_count = cnt; cfg_base_sel0 = b0; cfg_base_sel1 = b1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int mode, output int cyc);
    cyc = 0;
    while (!run_done && cyc < budget) begin
      @(posedge clk); #1;
      drive_ready(mode);
      cyc++;
    end
    if (!run_done) fail("run_done timeout");
  endtask

  task automatic finish_checks(input int s0, input int d0, input int cnt);
    @(posedge clk); #1;
    check("busy after run", busy, 1'b0);
    check("run_done single cycle", run_done, 1'b0);
    check("core_start pulses", 32'(n_start - s0), 32'(cnt));
    check("run_done pulses", 32'(n_done - d0), 32'd1);
    check("beats left over", 32'(exp_beats.size()), 32'd0);
    check("jobs left over", 32'(exp_issue.size()), 32'd0);
  endtask

  task automatic run_and_check(input logic [31:0] k0, input logic [15:0] cnt,
                               input logic [1:0] b0, input logic [1:0] b1,
                               input int mode, output int cyc);
    int s0, d0;
    s0 = n_start; d0 = n_done;
    drive_ready(mode);
    start_run(k0, cnt, b0, b1);
    wait_done(int'(cnt) * 40 + 100, mode, cyc);
    finish_checks(s0, d0, int'(cnt));
  endtask

  // Stimulus sequence
  initial begin
    int cyc, s0, d0;
    logic [31:0] k0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset run_done", run_done, 1'b0);
    check("reset core_start", core_start, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset core_k", core_k, 32'd0);
    check("reset base_sel", {core_base_sel0, core_base_sel1}, 4'd0);
    check("reset out data", {out_k, out_x, out_y, out_z}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic run k=1 count=2");
    run_and_check(32'd1, 16'd2, 2'd0, 2'd1, 0, cyc);

    $display("[TB] backpressure count=4");
    k0 = $urandom;
    s0 = n_start; d0 = n_done;
    out_ready = 1'b0;
    start_run(k0, 16'd4, 2'd2, 2'd1);
    repeat (60) @(posedge clk);
    #1;
    check("bp starts while stalled", 32'(n_start - s0), 32'd2);
    check("bp out_valid held", out_valid, 1'b1);
    check("bp busy", busy, 1'b1);
    check("bp head k", out_k, k0);
    wait_done(600, 1, cyc);
    finish_checks(s0, d0, 4);

    $display("[TB] zero count");
    run_and_check($urandom, 16'd0, 2'd3, 2'd3, 0, cyc);
    check("zero count run_done latency ok", cyc <= 2, 1'b1);

    $display("[TB] k wrap");
    run_and_check(32'hFFFF_FFFF, 16'd2, 2'd1, 2'd0, 0, cyc);

    $display("[TB] reset mid-run");
    s0 = n_start;
    out_ready = 1'b0;
    start_run($urandom, 16'd3, 2'd2, 2'd3);
    cyc = 0;
    while ((n_start - s0) < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if ((n_start - s0) < 2) fail("second job before reset");
    check("pre-reset out_valid", out_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid-run reset out_valid", out_valid, 1'b0);
    check("mid-run reset busy", busy, 1'b0);
    check("mid-run reset core_start", core_start, 1'b0);
    exp_beats.delete();
    exp_issue.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_and_check(32'd1, 16'd2, 2'd0, 2'd1, 0, cyc);

    $display("[TB] cfg_start re-pulsed mid-run");
    k0 = $urandom;
    s0 = n_start; d0 = n_done;
    drive_ready(0);
    start_run(k0, 16'd3, 2'd1, 2'd2);
    cyc = 0;
    while ((n_start - s0) < 1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    cfg_k_start = k0 + 32'd1000; cfg_count = 16'd1;
    cfg_base_sel0 = 2'd3; cfg_base_sel1 = 2'd0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_done(300, 0, cyc);
    finish_checks(s0, d0, 3);

    $display("[TB] random runs");
    for (int r = 0; r < 6; r++) begin
      run_and_check($urandom, 16'($urandom_range(1, 6)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 1), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
